// File: rtl/drawing_canvas_ctrl_pkg.sv
// Shared state encodings, colours and address helper for the drawing canvas controller.
package drawing_canvas_ctrl_pkg;

    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAINT  = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    localparam logic [2:0] COL_CURSOR = 3'b100;
    localparam logic [2:0] COL_INK    = 3'b000;
    localparam logic [2:0] COL_BLANK  = 3'b111;
    localparam logic [2:0] COL_BG     = 3'b000;

    localparam int ADDR_W = 10;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] x, input logic [4:0] y,
                                                    input int w);
        return ADDR_W'(y) * ADDR_W'(w) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/drawing_canvas_ctrl_if.sv
// Canvas readout stream: start pulse plus valid/ready beats carrying one cell each.
interface drawing_canvas_ctrl_if;
    logic rd_start;
    logic rd_valid;
    logic rd_data;
    logic rd_last;
    logic rd_ready;

    modport master (output rd_start, output rd_ready,
                    input  rd_valid, input  rd_data, input rd_last);
    modport slave  (input  rd_start, input  rd_ready,
                    output rd_valid, output rd_data, output rd_last);
endinterface

// File: rtl/drawing_canvas_ctrl_move_repeat.sv
// Turns held key levels into one-cycle cursor step pulses with a MOVE_DELAY auto-repeat.
module move_repeat #(
    parameter int MOVE_DELAY = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic key_dn,
    input  logic key_up,
    input  logic key_rt,
    input  logic key_lf,
    input  logic blk_dn,
    input  logic blk_up,
    input  logic blk_rt,
    input  logic blk_lf,
    output logic dn,
    output logic up,
    output logic rt,
    output logic lf
);
    localparam int TW = $clog2(MOVE_DELAY + 1);

    logic [TW-1:0] timer;
    logic go_dn, go_up, go_rt, go_lf, any_key, fire;

    // Keys pointing off the canvas are masked before priority so they never load the timer.
    always_comb begin
        go_dn   = key_dn & ~blk_dn;
        go_up   = key_up & ~blk_up;
        go_rt   = key_rt & ~blk_rt;
        go_lf   = key_lf & ~blk_lf;
        any_key = key_dn | key_up | key_rt | key_lf;
        fire    = enable && (timer == '0) && (go_dn | go_up | go_rt | go_lf);
        dn      = fire & go_dn;
        up      = fire & ~go_dn & go_up;
        rt      = fire & ~go_dn & ~go_up & go_rt;
        lf      = fire & ~go_dn & ~go_up & ~go_rt & go_lf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (enable) begin
            if (!any_key)
                timer <= '0;
            else if (fire)
                timer <= TW'(MOVE_DELAY);
            else if (timer != '0)
                timer <= timer - TW'(1);
        end
    end

endmodule

// File: rtl/drawing_canvas_ctrl.sv
// Drawing-grid controller: 1-bit canvas with cursor, brush painting, hardware clear,
// VGA colour lookup and row-major readout stream.
module drawing_canvas_ctrl
    import drawing_canvas_ctrl_pkg::*;
#(
    parameter int GRID_W     = 28,
    parameter int GRID_H     = 28,
    parameter int CELL_SHIFT = 2,
    parameter int OFF_X      = 10,
    parameter int OFF_Y      = 10,
    parameter int MOVE_DELAY = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_dn,
    input  logic       key_up,
    input  logic       key_rt,
    input  logic       key_lf,
    input  logic       pen_en,
    input  logic       erase_en,
    input  logic       brush_big,
    input  logic       clear_req,
    input  logic [7:0] vga_x,
    input  logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       busy,
    output logic [4:0] cur_x,
    output logic [4:0] cur_y,
    drawing_canvas_ctrl_if.slave rd
);
    localparam int N     = GRID_W * GRID_H;
    localparam int X_END = OFF_X + (GRID_W << CELL_SHIFT);
    localparam int Y_END = OFF_Y + (GRID_H << CELL_SHIFT);

    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_idx, rd_idx, waddr, vaddr;
    logic              mem [N];
    logic [4:0]        px, py, gx, gy;
    logic              pval, pbig;
    logic signed [5:0] dx, dy;
    logic [6:0]        tx, ty;
    logic              paint_ok, paint_done, we, wdata, in_canvas;
    logic              step_dn, step_up, step_rt, step_lf;

    assign busy = (state != ST_RUN);

    move_repeat #(.MOVE_DELAY(MOVE_DELAY)) u_move (
        .clk    (CLOCK_50),
        .rst_n  (resetn),
        .enable (state == ST_RUN || state == ST_PAINT),
        .key_dn (key_dn),
        .key_up (key_up),
        .key_rt (key_rt),
        .key_lf (key_lf),
        .blk_dn (cur_y == 5'(GRID_H - 1)),
        .blk_up (cur_y == 5'd0),
        .blk_rt (cur_x == 5'(GRID_W - 1)),
        .blk_lf (cur_x == 5'd0),
        .dn     (step_dn),
        .up     (step_up),
        .rt     (step_rt),
        .lf     (step_lf)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cur_x <= 5'(GRID_W / 2);
            cur_y <= 5'(GRID_H / 2);
        end else begin
            if (step_dn)      cur_y <= cur_y + 5'd1;
            else if (step_up) cur_y <= cur_y - 5'd1;
            else if (step_rt) cur_x <= cur_x + 5'd1;
            else if (step_lf) cur_x <= cur_x - 5'd1;
        end
    end

    // Brush target in 7-bit two's complement; bit 6 flags the -1 column/row off the canvas.
    always_comb begin
        tx         = {2'b00, px} + {dx[5], dx};
        ty         = {2'b00, py} + {dy[5], dy};
        paint_ok   = !tx[6] && !ty[6] && (tx < 7'(GRID_W)) && (ty < 7'(GRID_H));
        paint_done = !pbig || (dx == 6'sd1 && dy == 6'sd1);
        we         = 1'b0;
        waddr      = clr_idx;
        wdata      = 1'b0;
        if (state == ST_CLEAR) begin
            we = 1'b1;
        end else if (state == ST_PAINT) begin
            we    = paint_ok;
            waddr = cell_addr(tx[4:0], ty[4:0], GRID_W);
            wdata = pval;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_CLEAR;
            clr_idx     <= '0;
            rd_idx      <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
            rd.rd_data  <= 1'b0;
            px          <= '0;
            py          <= '0;
            pval        <= 1'b0;
            pbig        <= 1'b0;
            dx          <= '0;
            dy          <= '0;
        end else if (clear_req) begin
            state       <= ST_CLEAR;
            clr_idx     <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_idx == ADDR_W'(N - 1)) state <= ST_RUN;
                    else clr_idx <= clr_idx + ADDR_W'(1);
                end
                ST_RUN: begin
                    if (rd.rd_start) begin
                        state       <= ST_STREAM;
                        rd_idx      <= '0;
                        rd.rd_valid <= 1'b1;
                        rd.rd_data  <= mem[0];
                        rd.rd_last  <= 1'b0;
                    end else if (pen_en || erase_en) begin
                        state <= ST_PAINT;
                        px    <= cur_x;
                        py    <= cur_y;
                        pval  <= ~erase_en;
                        pbig  <= brush_big;
                        dx    <= brush_big ? -6'sd1 : 6'sd0;
                        dy    <= brush_big ? -6'sd1 : 6'sd0;
                    end
                end
                ST_PAINT: begin
                    if (paint_done) begin
                        state <= ST_RUN;
                    end else if (dx == 6'sd1) begin
                        dx <= -6'sd1;
                        dy <= dy + 6'sd1;
                    end else begin
                        dx <= dx + 6'sd1;
                    end
                end
                default: begin
                    if (rd.rd_valid && rd.rd_ready) begin
                        if (rd.rd_last) begin
                            state       <= ST_RUN;
                            rd.rd_valid <= 1'b0;
                            rd.rd_last  <= 1'b0;
                        end else begin
                            rd_idx     <= rd_idx + ADDR_W'(1);
                            rd.rd_data <= mem[rd_idx + ADDR_W'(1)];
                            rd.rd_last <= (rd_idx == ADDR_W'(N - 2));
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        in_canvas = (int'(vga_x) >= OFF_X) && (int'(vga_x) < X_END) &&
                    (int'(vga_y) >= OFF_Y) && (int'(vga_y) < Y_END);
        gx        = 5'((vga_x - 8'(OFF_X)) >> CELL_SHIFT);
        gy        = 5'((vga_y - 7'(OFF_Y)) >> CELL_SHIFT);
        vaddr     = cell_addr(gx, gy, GRID_W);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                         colour <= '0;
        else if (!in_canvas)                 colour <= COL_BG;
        else if (gx == cur_x && gy == cur_y) colour <= COL_CURSOR;
        else if (mem[vaddr])                 colour <= COL_INK;
        else                                 colour <= COL_BLANK;
    end

endmodule
